// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and Gray/binary pointer conversion helpers,
// used by both the read and write sides.
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int PTR_MAX_W  = 16;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended Gray input decodes to the zero-extended binary value.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer holding RAM read data in front of the consumer;
// entry 0 is always the head word.
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] e0, e1;
  logic              pop_ok;

  assign pop_ok = pop & (occ != 2'd0);
  assign dout   = e0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occ == 2'd0) e0 <= din;
          else             e1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        // Simultaneous push/pop: occupancy unchanged, new word goes behind the survivor.
        2'b11: begin
          if (occ == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-side controller: Gray read pointer, credit-based RAM reads
// into a 2-entry FWFT skid buffer. Optional fill level via FIFO_RD_LEVEL_EN.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr_sync,
  output logic [ADDR_W:0]   rptr,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_W:0]   rd_level,
  output logic              almost_empty
`endif
);

  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0] rbin, rbin_next;
  logic            inflight;
  logic [1:0]      occ;
  logic            ram_empty;
  logic            pop;
  logic [2:0]      credit;

  assign ram_empty = (rptr == wptr_sync);
  assign pop       = rd_valid & rd_ready;
  // Words that will sit in the buffer after this edge; never exceeds 2.
  assign credit    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign mem_ren   = rst & !ram_empty & (credit < 3'd2);
  assign rbin_next = rbin + PW'(mem_ren);
  assign mem_raddr = rbin[ADDR_W-1:0];

  // Stage 0 -> 1: address issue; read data returns with inflight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rbin     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      rbin     <= rbin_next;
      rptr     <= PW'(bin2gray(PTR_MAX_W'(rbin_next)));
      inflight <= mem_ren;
    end
  end

  // Stage 1 -> 2: returned word captured into the skid buffer.
  fifo_skid2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .din  (mem_rdata),
    .dout (rd_data),
    .occ  (occ)
  );

  assign rd_valid = (occ != 2'd0);
  assign empty    = !rst | (ram_empty & !inflight & (occ == 2'd0));

`ifdef FIFO_RD_LEVEL_EN
  localparam int LW = ADDR_W + 2;

  logic [ADDR_W:0] wbin;
  logic [LW-1:0]   level_next;

  assign wbin       = PW'(gray2bin(PTR_MAX_W'(wptr_sync)));
  assign level_next = LW'(PW'(wbin - rbin_next)) + LW'(mem_ren) + LW'(credit);

  always_ff @(posedge clk) begin
    if (!rst) rd_level <= '0;
    else      rd_level <= PW'(level_next);
  end

  assign almost_empty = !rst | (rd_level <= PW'(AE_THRESH));
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: bench-side RAM/write pointer, queue-based model
// checked every cycle, plus directed literal expectations.
module tb_fifo_read_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] wptr_sync = 5'd0;
  logic [4:0] rptr;
  logic       mem_ren;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata = 8'd0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [4:0] rd_level;
  logic       almost_empty;
`endif

  fifo_read_ctrl #(.ADDR_W(4), .DATA_W(8), .AE_THRESH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wptr_sync    (wptr_sync),
    .rptr         (rptr),
    .mem_ren      (mem_ren),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .empty        (empty)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level     (rd_level),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] ram [16];
  always @(posedge clk) if (mem_ren) mem_rdata <= ram[mem_raddr];

  int         n_checks = 0;
  int         n_fail = 0;
  int         wcount, reads, popped, cyc;
  bit         ren_last, check_en, hold, seen_top, seen_wrap, p;
  logic [7:0] hold_data;
  logic [7:0] exp_q[$];
  int         pop_cyc[$];
  int         lvl_exp = 0;
  int         buffered;

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    ram[wcount % 16] = d;
    exp_q.push_back(d);
    wcount++;
    wptr_sync = gray(wcount);
  endtask

  task automatic clear_model();
    wcount = 0; reads = 0; popped = 0; ren_last = 0;
    hold = 0; seen_top = 0; seen_wrap = 0;
    exp_q.delete();
    pop_cyc.delete();
  endtask

  task automatic do_reset();
    check_en = 0;
    step();
    rst = 0;
    rd_ready = 0;
    wptr_sync = 5'd0;
    clear_model();
    step();
    step();
    rst = 1;
    check_en = 1;
  endtask

  // Words held after each edge: everything written so far minus what was consumed.
  always @(posedge clk) lvl_exp = exp_q.size();

  always @(negedge clk) begin
    cyc++;
    if (check_en) begin
      p = rd_valid && rd_ready;
      buffered = reads - popped - int'(ren_last);
      chk("rd_valid", int'(rd_valid), int'(buffered > 0));
      chk("empty", int'(empty), int'(exp_q.size() == 0));
      chk("rptr", int'(rptr), int'(gray(reads)));
      chk("mem_raddr", int'(mem_raddr), reads % 16);
      chk("mem_ren", int'(mem_ren), int'((reads < wcount) && (reads - popped - int'(p) < 2)));
      if (hold) begin
        chk("hold_valid", int'(rd_valid), 1);
        chk("hold_data", int'(rd_data), int'(hold_data));
      end
      hold = rd_valid && !rd_ready;
      hold_data = rd_data;
      if (p) begin
        if (exp_q.size() == 0) chk("underflow", 1, 0);
        else chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
        popped++;
        pop_cyc.push_back(cyc);
      end
      if (rptr == 5'b10000) seen_top = 1;
      if (seen_top && rptr == 5'b00000) seen_wrap = 1;
      if (mem_ren) reads++;
      ren_last = mem_ren;
`ifdef FIFO_RD_LEVEL_EN
      chk("rd_level", int'(rd_level), lvl_exp);
      chk("almost_empty", int'(almost_empty), int'(lvl_exp <= 2));
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    check_en = 0;
    clear_model();
    rst = 0;
    wptr_sync = 5'b00011;

    // Reset held with a non-empty write pointer
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("rst_mem_ren", int'(mem_ren), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rptr", int'(rptr), 0);
      chk("rst_empty", int'(empty), 1);
`ifdef FIFO_RD_LEVEL_EN
      chk("rst_almost_empty", int'(almost_empty), 1);
      chk("rst_rd_level", int'(rd_level), 0);
`endif
    end
    do_reset();

    // Single word, no consumer
    step();
    put(8'hA5);
    @(negedge clk);
    chk("t2_ren_T", int'(mem_ren), 1);
    chk("t2_valid_T", int'(rd_valid), 0);
    step();
    @(negedge clk);
    chk("t2_ren_T1", int'(mem_ren), 0);
    chk("t2_valid_T1", int'(rd_valid), 0);
    chk("t2_rptr", int'(rptr), 1);
    step();
    @(negedge clk);
    chk("t2_valid_T2", int'(rd_valid), 1);
    chk("t2_data", int'(rd_data), 8'hA5);
    repeat (3) step();
    @(negedge clk);
    chk("t2_held_valid", int'(rd_valid), 1);
    chk("t2_held_rptr", int'(rptr), 1);
    step();
    rd_ready = 1;
    step();
    rd_ready = 0;
    @(negedge clk);
    chk("t2_empty", int'(empty), 1);
    chk("t2_valid_gone", int'(rd_valid), 0);

    // Streaming 16 words
    do_reset();
    step();
    rd_ready = 1;
    for (int i = 0; i < 16; i++) put(8'(8'h10 + i));
    for (int k = 0; k < 60 && popped < 16; k++) step();
    chk("t3_count", popped, 16);
    if (pop_cyc.size() == 16) chk("t3_consecutive", pop_cyc[15] - pop_cyc[0], 15);
    else chk("t3_pop_records", pop_cyc.size(), 16);
    @(negedge clk);
    chk("t3_rptr", int'(rptr), 24);
    chk("t3_empty", int'(empty), 1);

    // Backpressure with a full buffer
    step();
    rd_ready = 0;
    for (int i = 0; i < 5; i++) put(8'(8'h60 + i));
    repeat (5) step();
    @(negedge clk);
    chk("t4_ren_stalled", int'(mem_ren), 0);
    chk("t4_valid", int'(rd_valid), 1);
    chk("t4_head", int'(rd_data), 8'h60);
    chk("t4_rptr", int'(rptr), 27);
    repeat (3) step();
    @(negedge clk);
    chk("t4_head_stable", int'(rd_data), 8'h60);
    chk("t4_ren_still", int'(mem_ren), 0);
    step();
    rd_ready = 1;
    for (int k = 0; k < 40 && popped < 21; k++) step();
    chk("t4_drained", popped, 21);

    // Pointer wrap over 40 more words with irregular consumer
    n = 0;
    for (int k = 0; k < 600 && (n < 40 || popped < wcount); k++) begin
      step();
      rd_ready = (k % 3 != 2);
      if (n < 40 && (wcount - reads) < 16) begin
        put(8'(n * 7 + 3));
        n++;
      end
    end
    chk("t5_written", n, 40);
    chk("t5_drained", popped, wcount);
    chk("t5_seen_10000", int'(seen_top), 1);
    chk("t5_seen_wrap", int'(seen_wrap), 1);

    // Reset mid-operation discards buffered words
    step();
    rd_ready = 0;
    for (int i = 0; i < 3; i++) put(8'(8'h90 + i));
    repeat (4) step();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_valid", int'(rd_valid), 0);
      chk("t6_empty", int'(empty), 1);
      chk("t6_rptr", int'(rptr), 0);
      step();
    end

    // Fill level: 5 words, then 3 pops
    for (int i = 0; i < 5; i++) put(8'(8'hE0 + i));
    repeat (6) step();
    @(negedge clk);
    chk("t7_head", int'(rd_data), 8'hE0);
`ifdef FIFO_RD_LEVEL_EN
    chk("t7_level5", int'(rd_level), 5);
    chk("t7_ae0", int'(almost_empty), 0);
`endif
    step();
    rd_ready = 1;
    repeat (3) step();
    rd_ready = 0;
    repeat (2) step();
    @(negedge clk);
    chk("t7_popped", popped, 3);
    chk("t7_head_after", int'(rd_data), 8'hE3);
`ifdef FIFO_RD_LEVEL_EN
    chk("t7_level2", int'(rd_level), 2);
    chk("t7_ae1", int'(almost_empty), 1);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
